// File: rtl/layer_sequencer.sv
// layer_sequencer: per-sample control sequencer for the dilated conv1d layer chain.
// Define LAYER_SEQUENCER_CYCLE_STATS_EN to build the pass cycle counter behind cycles_last/cycles_max.
module layer_sequencer #(
    parameter int NUM_LAYERS = 4,
    parameter int TIMEOUT    = 1024,
    parameter int CW         = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_clk,
    input  logic                  clr_err,
    input  logic [NUM_LAYERS-1:0] conv_out_v,
    output logic                  lsb_shift,
    output logic [NUM_LAYERS-1:0] conv_rst,
    output logic [NUM_LAYERS-2:0] cache_shift,
    output logic                  out_latch,
    output logic                  busy,
    output logic [3:0]            layer_idx,
    output logic                  overrun,
    output logic [CW-1:0]         overrun_count,
    output logic                  timeout_err,
    output logic [CW-1:0]         cycles_last,
    output logic [CW-1:0]         cycles_max
);
    localparam int IW = $clog2(NUM_LAYERS);
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, SHIFT_IN, RST_CONV, WAIT_CONV, SHIFT_CACHE, LATCH_OUT} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              idx_q, idx_d;
    logic [WW-1:0]           wd_q, wd_d;
    logic                    prev_q;
    logic                    ovr_q, ovr_d, to_q, to_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    lsb_q, lsb_d, latch_q, latch_d, busy_q, busy_d;
    logic [NUM_LAYERS-1:0]   crst_q, crst_d;
    logic [NUM_LAYERS-2:0]   cshift_q, cshift_d;
    logic                    edge_det, vld, last, timeout, drop;

    always_comb begin
        edge_det = sample_clk && !prev_q;
        vld      = conv_out_v[idx_q[IW-1:0]];
        last     = idx_q == 4'(NUM_LAYERS - 1);
        timeout  = state_q == WAIT_CONV && !vld && wd_q == WW'(TIMEOUT - 1);
        drop     = edge_det && state_q != IDLE;
        state_d  = state_q;
        idx_d    = idx_q;
        wd_d     = wd_q;
        case (state_q)
            IDLE: begin
                state_d = edge_det ? SHIFT_IN : IDLE;
                idx_d   = '0;
            end
            SHIFT_IN:  state_d = RST_CONV;
            RST_CONV: begin
                state_d = WAIT_CONV;
                wd_d    = '0;
            end
            WAIT_CONV: begin
                // a valid arriving on the final watchdog cycle still counts
                state_d = vld ? (last ? LATCH_OUT : SHIFT_CACHE) : timeout ? IDLE : WAIT_CONV;
                idx_d   = (!vld && timeout) ? '0 : idx_q;
                wd_d    = wd_q + WW'(1);
            end
            SHIFT_CACHE: begin
                state_d = RST_CONV;
                idx_d   = idx_q + 4'd1;
            end
            LATCH_OUT: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
        ovr_d    = drop || (ovr_q && !clr_err);
        cnt_d    = clr_err ? CW'(drop) : (drop && !(&cnt_q)) ? cnt_q + CW'(1) : cnt_q;
        to_d     = timeout || (to_q && !clr_err);
        lsb_d    = state_d == SHIFT_IN;
        latch_d  = state_d == LATCH_OUT;
        busy_d   = state_d != IDLE;
        crst_d   = state_d == RST_CONV ? NUM_LAYERS'(1) << idx_d : '0;
        cshift_d = state_d == SHIFT_CACHE ? (NUM_LAYERS - 1)'(1) << idx_d : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            wd_q     <= '0;
            prev_q   <= 1'b1;
            ovr_q    <= 1'b0;
            cnt_q    <= '0;
            to_q     <= 1'b0;
            lsb_q    <= 1'b0;
            latch_q  <= 1'b0;
            busy_q   <= 1'b0;
            crst_q   <= '0;
            cshift_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wd_q     <= wd_d;
            prev_q   <= sample_clk;
            ovr_q    <= ovr_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
            lsb_q    <= lsb_d;
            latch_q  <= latch_d;
            busy_q   <= busy_d;
            crst_q   <= crst_d;
            cshift_q <= cshift_d;
        end
    end

    assign lsb_shift     = lsb_q;
    assign conv_rst      = crst_q;
    assign cache_shift   = cshift_q;
    assign out_latch     = latch_q;
    assign busy          = busy_q;
    assign layer_idx     = idx_q;
    assign overrun       = ovr_q;
    assign overrun_count = cnt_q;
    assign timeout_err   = to_q;

`ifdef LAYER_SEQUENCER_CYCLE_STATS_EN
    logic [CW-1:0] cyc_q, cyc_d, last_q, last_d, max_q, max_d;

    // cyc_q holds the 1-based index of the current pass cycle
    always_comb begin
        cyc_d  = state_d == SHIFT_IN ? CW'(1) : (&cyc_q) ? cyc_q : cyc_q + CW'(1);
        last_d = state_q == LATCH_OUT ? cyc_q : last_q;
        max_d  = clr_err ? (state_q == LATCH_OUT ? cyc_q : '0)
               : (state_q == LATCH_OUT && cyc_q > max_q) ? cyc_q : max_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q  <= '0;
            last_q <= '0;
            max_q  <= '0;
        end else begin
            cyc_q  <= cyc_d;
            last_q <= last_d;
            max_q  <= max_d;
        end
    end

    assign cycles_last = last_q;
    assign cycles_max  = max_q;
`else
    assign cycles_last = '0;
    assign cycles_max  = '0;
`endif
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: schedule-model bench for layer_sequencer (4 layers, 12-cycle watchdog).
module tb_layer_sequencer;
    localparam int NL = 4;
    localparam int TO = 12;
    localparam int CW = 16;

    logic          clk = 0, rst = 1, sample_clk = 1, clr_err = 0;
    logic [NL-1:0] conv_out_v = '0;
    logic          lsb_shift, out_latch, busy, overrun, timeout_err;
    logic [NL-1:0] conv_rst;
    logic [NL-2:0] cache_shift;
    logic [3:0]    layer_idx;
    logic [CW-1:0] overrun_count, cycles_last, cycles_max;

    layer_sequencer #(.NUM_LAYERS(NL), .TIMEOUT(TO), .CW(CW)) dut (
        .clk(clk), .rst(rst), .sample_clk(sample_clk), .clr_err(clr_err),
        .conv_out_v(conv_out_v), .lsb_shift(lsb_shift), .conv_rst(conv_rst),
        .cache_shift(cache_shift), .out_latch(out_latch), .busy(busy),
        .layer_idx(layer_idx), .overrun(overrun), .overrun_count(overrun_count),
        .timeout_err(timeout_err), .cycles_last(cycles_last), .cycles_max(cycles_max)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0]   e;
        logic [NL-1:0] v;
    } step_t;

    step_t       q[$];
    int          vectors = 0, miscompares = 0;
    logic        m_ovr = 0, m_to = 0;
    int          m_cnt = 0, m_last = 0, m_max = 0;
    logic [13:0] obs;
    logic [49:0] st;

    assign obs = {busy, layer_idx, lsb_shift, conv_rst, cache_shift, out_latch};
    assign st  = {overrun, overrun_count, timeout_err, cycles_last, cycles_max};

    function automatic logic [13:0] mk(logic b, int i, logic l, logic [3:0] cr, logic [2:0] cs, logic lt);
        return {b, 4'(i), l, cr, cs, lt};
    endfunction

    function automatic logic [49:0] exp_st();
`ifdef LAYER_SEQUENCER_CYCLE_STATS_EN
        return {m_ovr, CW'(m_cnt), m_to, CW'(m_last), CW'(m_max)};
`else
        return {m_ovr, CW'(m_cnt), m_to, 32'd0};
`endif
    endfunction

    function automatic logic [3:0] rnd();
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic model_clear();
        m_ovr = 0; m_cnt = 0; m_to = 0; m_last = 0; m_max = 0;
    endtask

    // ws nibble i = WAIT cycles before layer i's valid (0 = never valid)
    task automatic run_pass(input string name, input logic [15:0] ws, input int ovr_cyc,
                            input bit ovr_clr, input int rst_cyc);
        int  w, oc;
        bit  timed_out = 0, aborted = 0;
        logic [3:0] v;
        q.delete();
        q.push_back('{mk(1, 0, 1, 0, 0, 0), rnd()});
        for (int i = 0; i < NL; i++) begin
            q.push_back('{mk(1, i, 0, 4'(1) << i, 0, 0), rnd()});
            w = ws[4*i +: 4] == 0 ? TO : int'(ws[4*i +: 4]);
            for (int j = 1; j <= w; j++) begin
                v = rnd() & ~(4'(1) << i);
                if (ws[4*i +: 4] != 0 && j == w) v = v | (4'(1) << i);
                q.push_back('{mk(1, i, 0, 0, 0, 0), v});
            end
            if (ws[4*i +: 4] == 0) begin
                timed_out = 1;
                break;
            end
            if (i < NL - 1) q.push_back('{mk(1, i, 0, 0, 3'(1) << i, 0), rnd()});
        end
        if (!timed_out) q.push_back('{mk(1, NL - 1, 0, 0, 0, 1), rnd()});
        oc = (ovr_cyc < 2 || ovr_cyc > q.size()) ? 0 : ovr_cyc;
        sample_clk = 1;
        @(posedge clk); @(negedge clk);
        for (int k = 1; k <= q.size(); k++) begin
            vectors++;
            if (obs !== q[k-1].e) begin
                miscompares++;
                $display("FAIL %s strobes cyc %0d: got %h want %h", name, k, obs, q[k-1].e);
            end
            sample_clk = (k == oc);
            clr_err    = (k == oc) && ovr_clr;
            conv_out_v = q[k-1].v;
            if (k == rst_cyc) begin
                sample_clk = 0; clr_err = 0;
                #2 rst = 1;
                model_clear();
                #1 vectors++;
                if (obs !== 14'd0 || st !== exp_st()) begin
                    miscompares++;
                    $display("FAIL %s async_rst: got %h/%h want 0", name, obs, st);
                end
                @(negedge clk);
                rst = 0;
                aborted = 1;
                break;
            end
            @(posedge clk); @(negedge clk);
        end
        sample_clk = 0; clr_err = 0; conv_out_v = '0;
        if (!aborted) begin
            if (oc != 0) begin
                if (ovr_clr) begin
                    m_cnt = 0; m_to = 0; m_max = 0;
                end
                m_ovr = 1;
                m_cnt = m_cnt < 65535 ? m_cnt + 1 : m_cnt;
            end
            if (timed_out) m_to = 1;
            else begin
                m_last = q.size();
                m_max  = m_last > m_max ? m_last : m_max;
            end
            vectors++;
            if (st !== exp_st()) begin
                miscompares++;
                $display("FAIL %s status: got %h want %h", name, st, exp_st());
            end
        end
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs !== 14'd0) begin
                miscompares++;
                $display("FAIL %s idle %0d: got %h want 0", name, k, obs);
            end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if (obs !== 14'd0 || st !== 50'd0) begin
            miscompares++;
            $display("FAIL reset: got %h/%h want 0", obs, st);
        end
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); @(negedge clk);
            vectors++;
            if (obs !== 14'd0) begin
                miscompares++;
                $display("FAIL reset_high_sample %0d: got %h want 0", k, obs);
            end
        end
        sample_clk = 0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_clr();
        clr_err = 1;
        @(posedge clk); @(negedge clk);
        clr_err = 0;
        m_ovr = 0; m_cnt = 0; m_to = 0; m_max = 0;
        vectors++;
        if (st !== exp_st()) begin
            miscompares++;
            $display("FAIL clr_err: got %h want %h", st, exp_st());
        end
    endtask

    task automatic test_random();
        logic [15:0] ws;
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < NL; i++)
                ws[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, TO - 1));
            run_pass("random", ws, $urandom_range(0, 40), 1'($urandom_range(0, 1)), 0);
            if ($urandom_range(0, 5) == 0) test_clr();
        end
    endtask

    initial begin
        test_reset();
        run_pass("fast", 16'h1111, 0, 0, 0);
        run_pass("delayed", 16'h1A11, 0, 0, 0);
        run_pass("fast_after_slow", 16'h1111, 0, 0, 0);
        run_pass("overrun", 16'h1111, 5, 0, 0);
        test_clr();
        run_pass("timeout", 16'h1101, 0, 0, 0);
        run_pass("after_timeout", 16'h1111, 0, 0, 0);
        run_pass("latch_drop", 16'h1111, 13, 0, 0);
        run_pass("overrun2", 16'h2131, 7, 0, 0);
        run_pass("clr_collide", 16'h1111, 6, 1, 0);
        run_pass("near_timeout", 16'hB111, 0, 0, 0);
        run_pass("mid_reset", 16'h5111, 0, 0, 13);
        run_pass("after_reset", 16'h1111, 0, 0, 0);
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Parametrised control sequencer for the dilated conv1d inference chain, serving NUM_LAYERS layers.
- On each rising edge of the sample clock it performs, in order:
  - one shift of the input left-shift buffers;
  - for each layer: reset/start the conv, wait for its valid, shift that layer's activation cache;
  - one output-latch strobe.
- Adds a per-layer timeout watchdog, overrun detection, and sticky error status. Sits between the codec sample clock and the conv1d/activation_cache/left_shift_buffer instances.

Parameters:
- NUM_LAYERS, 4, number of conv layers in the chain (2..16).
- TIMEOUT, 1024, maximum clk cycles a layer may spend in WAIT before abort (>=2).
- CW, 16, width of the cycle-stat and overrun counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- sample_clk  in  1  sample-rate strobe, synchronous to clk; rising edge starts a pass.
- clr_err  in  1  one-cycle pulse; clears sticky errors and overrun_count.
- conv_out_v  in  NUM_LAYERS  per-layer conv valid, bit i = layer i.
- lsb_shift  out  1  one-cycle strobe to the input left-shift buffers.
- conv_rst  out  NUM_LAYERS  one-hot one-cycle reset/start strobe to conv i.
- cache_shift  out  NUM_LAYERS-1  one-cycle strobe to the activation cache after layer i.
- out_latch  out  1  one-cycle strobe to latch the final conv output.
- busy  out  1  high whenever state != IDLE.
- layer_idx  out  4  active layer index; 0 in IDLE.
- overrun  out  1  sticky; sample edge arrived while busy.
- overrun_count  out  CW  saturating count of dropped edges.
- timeout_err  out  1  sticky; a layer exceeded TIMEOUT.
- cycles_last  out  CW  cycle count of the last completed pass.
- cycles_max  out  CW  maximum of cycles_last since reset/clr_err.

Behaviour:
- Reset (async, rst=1): state=IDLE; every output 0; layer index 0. Edge-detect register prev=1, so a high sample_clk at reset release is not an edge.
- Edge: detected on the clk posedge where sample_clk=1 and prev=0.
- States: IDLE, SHIFT_IN, RST_CONV, WAIT_CONV, SHIFT_CACHE, LATCH_OUT.
- Transitions:
  - IDLE -edge-> SHIFT_IN (idx=0).
  - SHIFT_IN -> RST_CONV.
  - RST_CONV -> WAIT_CONV.
  - WAIT_CONV, conv_out_v[idx]=1: go to SHIFT_CACHE if idx<NUM_LAYERS-1, else LATCH_OUT.
  - SHIFT_CACHE -> RST_CONV with idx+1.
  - LATCH_OUT -> IDLE.
- Strobes are registered and high for exactly the one cycle spent in the matching state:
  - lsb_shift in SHIFT_IN;
  - conv_rst[idx] in RST_CONV;
  - cache_shift[idx] in SHIFT_CACHE;
  - out_latch in LATCH_OUT.
- conv_out_v is qualified only in WAIT_CONV and only on bit idx. Other bits and other states are ignored.
- Minimum pass length, counted from SHIFT_IN through LATCH_OUT inclusive: 3*NUM_LAYERS+1 cycles (13 for NUM_LAYERS=4).
- Watchdog:
  - A counter clears on entry to WAIT_CONV.
  - If it reaches TIMEOUT without valid: timeout_err<=1, state -> IDLE, no out_latch, cycles_last unchanged.
- Overrun:
  - An edge while state != IDLE is dropped; the pass in progress continues.
  - overrun<=1; overrun_count increments, saturating at 2^CW-1.
  - An edge on the LATCH_OUT cycle is also dropped.
- Error clear:
  - clr_err clears overrun, overrun_count, timeout_err and cycles_max.
  - If clr_err coincides with a new error event in the same cycle, the new event wins: flag=1, count=1.
- rst mid-pass: immediate return to IDLE; all strobes drop asynchronously.

Optional Feature:
- Macro: LAYER_SEQUENCER_CYCLE_STATS_EN.
- Defined:
  - A pass cycle counter runs from SHIFT_IN, saturating at 2^CW-1.
  - On LATCH_OUT, cycles_last<=count including the LATCH_OUT cycle.
  - cycles_max<=max(cycles_max, that count).
- Undefined: the counter logic is absent; cycles_last and cycles_max are tied to 0.

Test Plan:
- NUM_LAYERS=4, conv_out_v[idx] driven high on the first WAIT cycle, one sample edge -> strobes in this order:
  - lsb_shift;
  - conv_rst=0001, cache_shift[0];
  - conv_rst=0010, cache_shift[1];
  - conv_rst=0100, cache_shift[2];
  - conv_rst=1000, out_latch.
  - out_latch arrives 13 cycles after the edge-detect posedge; cycles_last=13 (with stats enabled).
- Layer 2 valid delayed 10 WAIT cycles -> cycles_last=22, cycles_max=22. A following fast pass gives cycles_last=13 and leaves cycles_max=22.
- Second sample edge 5 cycles into a pass -> pass still completes with exactly one out_latch; overrun=1, overrun_count=1. clr_err then clears both to 0.
- TIMEOUT=8, layer 1 valid never asserted -> IDLE after 8 WAIT cycles; timeout_err=1; no out_latch and no cache_shift[1]. The next edge runs a full normal pass.
- sample_clk held high through reset release -> no pass starts. rst asserted during WAIT of layer 3 -> all outputs 0 asynchronously; the next edge starts cleanly at layer 0.
- clr_err in the same cycle as a dropped edge -> overrun=1, overrun_count=1. Stale conv_out_v on a non-active bit -> ignored, no early advance.
